// File: rtl/reg_writeback_if.sv
// Bundle of the write-request, commit and forwarding-lookup signals of the
// register write-back queue. The producer/bank/operand side uses "master";
// the queue itself uses "slave".
interface reg_writeback_if #(
    parameter int XLEN = 64
);
    logic            wr_valid;
    logic            wr_ready;
    logic [4:0]      wr_idx;
    logic [XLEN-1:0] wr_data;

    logic            commit_stall;
    logic            commit_en;
    logic [4:0]      commit_idx;
    logic [XLEN-1:0] commit_data;

    logic [4:0]      rd_idx;
    logic            rd_pending;
    logic [XLEN-1:0] rd_fwd_data;

    logic            empty;
    logic            err_illegal;

    modport master (
        output wr_valid, wr_idx, wr_data, commit_stall, rd_idx,
        input  wr_ready, commit_en, commit_idx, commit_data,
               rd_pending, rd_fwd_data, empty, err_illegal
    );

    modport slave (
        input  wr_valid, wr_idx, wr_data, commit_stall, rd_idx,
        output wr_ready, commit_en, commit_idx, commit_data,
               rd_pending, rd_fwd_data, empty, err_illegal
    );
endinterface

// File: rtl/reg_writeback.sv
// In-order write-back queue in front of the 18-entry register bank
// (g0-g15, fp, sp). Buffers accepted writes, drains one per cycle to the
// bank and lets the operand stage see values that have not landed yet.
module reg_writeback #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic          clk,
    input  logic          reset,
    reg_writeback_if.slave bus
);
    localparam int         PW       = $clog2(DEPTH);
    localparam int         CW       = PW + 1;
    localparam logic [4:0] NUM_REGS = 5'd18;

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;

    logic [4:0]      idx_q  [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    logic            full;
    logic            is_empty;
    logic            accept;
    logic            legal;
    logic            push;
    logic            pop;

    logic            hit;
    logic [XLEN-1:0] fwd_data;
    logic [PW-1:0]   slot;

    assign full     = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    assign accept   = bus.wr_valid && !full;
    assign legal    = (bus.wr_idx < NUM_REGS);
    assign push     = accept && legal;
    assign pop      = !is_empty && !bus.commit_stall;

    assign bus.wr_ready    = !full;
    assign bus.empty       = is_empty;
    assign bus.commit_en   = pop;
    assign bus.commit_idx  = is_empty ? '0 : idx_q[head_q];
    assign bus.commit_data = is_empty ? '0 : data_q[head_q];
    assign bus.rd_pending  = hit;
    assign bus.rd_fwd_data = fwd_data;
    assign bus.err_illegal = err_q;

    // Next pointer, occupancy and sticky-error values from this cycle's push/pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q | (accept && !legal);
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and error registers; reset drops every queued write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Entry storage: a committed slot loses its valid bit so a wrapped pointer never sees a stale match.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (pop) begin
                vld_q[head_q] <= 1'b0;
            end
            if (push) begin
                vld_q[tail_q]  <= 1'b1;
                idx_q[tail_q]  <= bus.wr_idx;
                data_q[tail_q] <= bus.wr_data;
            end
        end
    end

    // Walk entries oldest to youngest so the last match found is the youngest one.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_q + PW'(k);
            if (vld_q[slot] && (idx_q[slot] == bus.rd_idx)) begin
                hit      = 1'b1;
                fwd_data = data_q[slot];
            end
        end
    end
endmodule
